ysyx_23060171_trap_ctrl: RTL and testbench

Trap sequencer for the NPC core. It accepts exception requests (ecall, ebreak, illegal instruction) and `mret` requests from the write-back stage. It drives the machine-mode CSR file's single write port to save `mepc`, `mcause` and `mstatus` state, then redirects the IFU to `mtvec` (trap) or `mepc` (`mret`) through a valid/ready handshake. It asserts a pipeline flush for the whole sequence.

---
 rtl/ysyx_23060171_trap_ctrl.sv | 159 +++++++++++++++
 tb/tb_ysyx_23060171_trap_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060171_trap_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_trap_ctrl
//
// Trap sequencer for the NPC core. It takes exception and mret requests from
// write-back and drives the machine CSR file's single write port. For a trap
// it saves mepc, then mcause, then the mstatus update. For an mret it
// restores mstatus. It then offers a PC redirect to the IFU (mtvec for a
// trap, mepc for an mret) through a valid/ready handshake. Flush stays high
// for the whole sequence.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   exc_valid       exception request; exc_cause / exc_pc carry its payload
//   mret_valid      mret retire request
//   req_ready       request accepted this cycle (shared by exc and mret)
//   csr_wen/waddr/wdata   CSR write port, one write per cycle at most
//   csr_raddr/rdata       combinational CSR read port (mstatus only)
//   mtvec, mepc     current CSR values supplied by the CSR file
//   redirect_valid/pc/ready   PC redirect handshake towards the IFU
//   flush           kill younger in-flight instructions
//   busy            sequencer is not idle
// ---------------------------------------------------------------------------
module ysyx_23060171_trap_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_valid,
  input  logic [7:0]            exc_cause,
  input  logic [DATA_WIDTH-1:0] exc_pc,
  input  logic                  mret_valid,
  output logic                  req_ready,
  output logic                  csr_wen,
  output logic [ADDR_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [ADDR_WIDTH-1:0] csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic [DATA_WIDTH-1:0] mtvec,
  input  logic [DATA_WIDTH-1:0] mepc,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  redirect_ready,
  output logic                  flush,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MSTATUS = ADDR_WIDTH'(12'h300);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MEPC    = ADDR_WIDTH'(12'h341);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MCAUSE  = ADDR_WIDTH'(12'h342);

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_STATUS,
    M_STATUS,
    REDIRECT
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [7:0]            cause_q;
  logic [DATA_WIDTH-1:0] target_q;
  logic [DATA_WIDTH-1:0] status_new;

  // Vectored mtvec mode is not supported, so the mode bits are never used.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];

  // Sequencer state plus the request payload and redirect target latches.
  // An exception has priority over a simultaneous mret; the mret is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_valid) begin
            pc_q    <= exc_pc;
            cause_q <= exc_cause;
            state   <= W_EPC;
          end else if (mret_valid) begin
            state <= M_STATUS;
          end
        end
        W_EPC:    state <= W_CAUSE;
        W_CAUSE:  state <= W_STATUS;
        W_STATUS: begin
          target_q <= {mtvec[DATA_WIDTH-1:2], 2'b00};
          state    <= REDIRECT;
        end
        // mepc already reflects every write committed before this cycle.
        M_STATUS: begin
          target_q <= mepc;
          state    <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state <= IDLE;
          end
        end
        default:  state <= IDLE;
      endcase
    end
  end

  // CSR port decode. The mstatus update is a read-modify-write in a single
  // cycle, because the read port is combinational.
  always_comb begin
    csr_wen    = 1'b0;
    csr_waddr  = '0;
    csr_wdata  = '0;
    csr_raddr  = '0;
    status_new = csr_rdata;
    case (state)
      W_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = ADDR_MEPC;
        csr_wdata = {pc_q[DATA_WIDTH-1:2], 2'b00};
      end
      W_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = ADDR_MCAUSE;
        csr_wdata = {{(DATA_WIDTH-8){1'b0}}, cause_q};
      end
      W_STATUS: begin
        status_new[7]     = csr_rdata[3];
        status_new[3]     = 1'b0;
        status_new[12:11] = 2'b11;
        csr_raddr         = ADDR_MSTATUS;
        csr_wen           = 1'b1;
        csr_waddr         = ADDR_MSTATUS;
        csr_wdata         = status_new;
      end
      M_STATUS: begin
        status_new[3]     = csr_rdata[7];
        status_new[7]     = 1'b1;
        status_new[12:11] = 2'b11;
        csr_raddr         = ADDR_MSTATUS;
        csr_wen           = 1'b1;
        csr_waddr         = ADDR_MSTATUS;
        csr_wdata         = status_new;
      end
      default: ;
    endcase
  end

  assign busy           = (state != IDLE);
  assign req_ready      = (state == IDLE);
  assign redirect_valid = (state == REDIRECT);
  assign redirect_pc    = target_q;
  // Flush starts in the accepting cycle itself and then covers every busy cycle.
  assign flush          = busy | (req_ready & (exc_valid | mret_valid));

endmodule

// File: tb/tb_ysyx_23060171_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060171_trap_ctrl
//
// Self-checking bench for the trap sequencer. A small CSR model holds
// mstatus and mepc and applies the DUT's writes. Expected CSR writes and
// redirect targets go into queues when a request is driven. A negedge
// monitor pops them as the DUT produces writes and redirect handshakes.
// Directed tasks also check the cycle-by-cycle control timing.
// ---------------------------------------------------------------------------
module tb_ysyx_23060171_trap_ctrl;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          exc_valid = 1'b0;
  logic [7:0]    exc_cause = '0;
  logic [DW-1:0] exc_pc = '0;
  logic          mret_valid = 1'b0;
  logic          req_ready;
  logic          csr_wen;
  logic [AW-1:0] csr_waddr;
  logic [DW-1:0] csr_wdata;
  logic [AW-1:0] csr_raddr;
  logic [DW-1:0] csr_rdata;
  logic [DW-1:0] mtvec = 32'h8000_0101;
  logic [DW-1:0] mepc;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          redirect_ready = 1'b1;
  logic          flush;
  logic          busy;

  ysyx_23060171_trap_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_valid(mret_valid), .req_ready(req_ready),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .mtvec(mtvec), .mepc(mepc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush), .busy(busy)
  );

  // 10 time-unit clock period.
  always #5 clk = ~clk;

  // CSR file model. A preload stands in for software csrw before a test.
  // Otherwise the model commits DUT writes at the rising edge that ends the write cycle.
  logic          preload = 1'b0;
  logic [DW-1:0] preload_status = '0;
  logic [DW-1:0] preload_epc = '0;
  logic [DW-1:0] mstatus_m = '0;
  logic [DW-1:0] mepc_m = '0;

  always @(posedge clk) begin
    if (preload) begin
      mstatus_m <= preload_status;
      mepc_m    <= preload_epc;
    end else if (csr_wen) begin
      if (csr_waddr == 12'h300) mstatus_m <= csr_wdata;
      if (csr_waddr == 12'h341) mepc_m    <= csr_wdata;
    end
  end

  assign csr_rdata = (csr_raddr == 12'h300) ? mstatus_m : '0;
  assign mepc      = mepc_m;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr_q[$];
  logic [DW-1:0] exp_pc_q[$];
  int            checks = 0;
  int            failures = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor. Every CSR write and every redirect handshake must
  // match the next expected entry. Writes made while reset is high are not
  // tracked, because they belong to an aborted sequence.
  wr_t           mon_wr;
  logic [DW-1:0] mon_pc;
  always @(negedge clk) begin
    if (!rst && csr_wen) begin
      if (exp_wr_q.size() == 0) begin
        checkOutput("unexpected_csr_write", 32'(csr_waddr), 32'hFFFF_FFFF);
      end else begin
        mon_wr = exp_wr_q.pop_front();
        checkOutput("sb_csr_waddr", 32'(csr_waddr), 32'(mon_wr.addr));
        checkOutput("sb_csr_wdata", csr_wdata, mon_wr.data);
      end
    end
    if (!rst && redirect_valid && redirect_ready) begin
      if (exp_pc_q.size() == 0) begin
        checkOutput("unexpected_redirect", redirect_pc, ~redirect_pc);
      end else begin
        mon_pc = exp_pc_q.pop_front();
        checkOutput("sb_redirect_pc", redirect_pc, mon_pc);
      end
    end
  end

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic exc, input logic mret,
                               input logic [DW-1:0] pc, input logic [7:0] cause);
    exc_valid  = exc;
    mret_valid = mret;
    exc_pc     = pc;
    exc_cause  = cause;
  endtask

  task automatic preloadCsr(input logic [DW-1:0] st, input logic [DW-1:0] epc);
    preload        = 1'b1;
    preload_status = st;
    preload_epc    = epc;
    tick();
    preload        = 1'b0;
  endtask

  // Reference mstatus transforms for trap entry and mret.
  function automatic logic [DW-1:0] trapStatus(input logic [DW-1:0] s);
    logic [DW-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [DW-1:0] mretStatus(input logic [DW-1:0] s);
    logic [DW-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  task automatic expectAccept(input string tag);
    @(negedge clk);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 1);
    checkOutput({tag, "_flush"}, 32'(flush), 1);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic expectWrite(input string tag, input logic [AW-1:0] addr);
    @(negedge clk);
    checkOutput({tag, "_wen"}, 32'(csr_wen), 1);
    checkOutput({tag, "_waddr"}, 32'(csr_waddr), 32'(addr));
    checkOutput({tag, "_flush"}, 32'(flush), 1);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 0);
    checkOutput({tag, "_redirect_valid"}, 32'(redirect_valid), 0);
    tick();
  endtask

  task automatic expectRedirect(input string tag, input logic [DW-1:0] pc);
    @(negedge clk);
    checkOutput({tag, "_redirect_valid"}, 32'(redirect_valid), 1);
    checkOutput({tag, "_redirect_pc"}, redirect_pc, pc);
    checkOutput({tag, "_flush"}, 32'(flush), 1);
    checkOutput({tag, "_wen"}, 32'(csr_wen), 0);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 0);
    tick();
  endtask

  task automatic expectIdle(input string tag, input logic exp_flush);
    @(negedge clk);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 1);
    checkOutput({tag, "_wen"}, 32'(csr_wen), 0);
    checkOutput({tag, "_redirect_valid"}, 32'(redirect_valid), 0);
    checkOutput({tag, "_flush"}, 32'(flush), 32'(exp_flush));
  endtask

  // Full trap sequence with redirect_ready held high.
  task automatic runTrap(input string tag, input logic [DW-1:0] pc, input logic [7:0] cause,
                         input logic [DW-1:0] st, input logic [DW-1:0] exp_st,
                         input logic [DW-1:0] exp_target, input logic with_mret);
    preloadCsr(st, '0);
    exp_wr_q.push_back('{addr: 12'h341, data: {pc[DW-1:2], 2'b00}});
    exp_wr_q.push_back('{addr: 12'h342, data: {24'b0, cause}});
    exp_wr_q.push_back('{addr: 12'h300, data: exp_st});
    exp_pc_q.push_back(exp_target);
    applyStimulus(1'b1, with_mret, pc, cause);
    expectAccept(tag);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    expectWrite({tag, "_epc"}, 12'h341);
    expectWrite({tag, "_cause"}, 12'h342);
    expectWrite({tag, "_status"}, 12'h300);
    expectRedirect(tag, exp_target);
    expectIdle({tag, "_done"}, 1'b0);
    tick();
  endtask

  task automatic runMret(input string tag, input logic [DW-1:0] st,
                         input logic [DW-1:0] exp_st, input logic [DW-1:0] epc);
    preloadCsr(st, epc);
    exp_wr_q.push_back('{addr: 12'h300, data: exp_st});
    exp_pc_q.push_back(epc);
    applyStimulus(1'b0, 1'b1, '0, '0);
    expectAccept(tag);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    expectWrite({tag, "_status"}, 12'h300);
    expectRedirect(tag, epc);
    expectIdle({tag, "_done"}, 1'b0);
    tick();
  endtask

  logic [DW-1:0] rnd_st;
  logic [DW-1:0] rnd_pc;
  logic [7:0]    rnd_cause;

  // Main sequence: reset, then the directed cases, then a few randomized
  // traps and mrets.
  initial begin
    $display("[TB] start");

    // Reset held for two cycles.
    tick();
    tick();
    expectIdle("reset", 1'b0);
    rst = 1'b0;
    tick();
    expectIdle("post_reset", 1'b0);
    tick();

    // ecall with the reference values.
    runTrap("ecall", 32'h8000_0010, 8'd11, 32'h0000_1808, 32'h0000_1880, 32'h8000_0100, 1'b0);

    // mret with the reference values.
    runMret("mret", 32'h0000_1880, 32'h0000_1888, 32'h8000_0014);

    // A simultaneous mret is dropped; any M_STATUS write would break the scoreboard.
    mtvec = 32'h2000_0042;
    runTrap("both", 32'h8000_0203, 8'd2, 32'h0000_0000, 32'h0000_1800, 32'h2000_0040, 1'b1);
    mtvec = 32'h8000_0101;

    // Back-pressure. While the first trap stalls in REDIRECT, a second
    // exception is held; it must be accepted in the first idle cycle.
    preloadCsr(32'h0000_1808, '0);
    exp_wr_q.push_back('{addr: 12'h341, data: 32'h8000_0030});
    exp_wr_q.push_back('{addr: 12'h342, data: 32'h0000_000B});
    exp_wr_q.push_back('{addr: 12'h300, data: 32'h0000_1880});
    exp_pc_q.push_back(32'h8000_0100);
    exp_wr_q.push_back('{addr: 12'h341, data: 32'h8000_0444});
    exp_wr_q.push_back('{addr: 12'h342, data: 32'h0000_0003});
    exp_wr_q.push_back('{addr: 12'h300, data: 32'h0000_1800});
    exp_pc_q.push_back(32'h8000_0100);
    applyStimulus(1'b1, 1'b0, 32'h8000_0030, 8'd11);
    expectAccept("bp");
    tick();
    applyStimulus(1'b1, 1'b0, 32'h8000_0444, 8'd3);
    redirect_ready = 1'b0;
    expectWrite("bp_epc", 12'h341);
    expectWrite("bp_cause", 12'h342);
    expectWrite("bp_status", 12'h300);
    for (int i = 0; i < 5; i++) expectRedirect("bp_stall", 32'h8000_0100);
    redirect_ready = 1'b1;
    expectRedirect("bp_release", 32'h8000_0100);
    expectIdle("bp_idle", 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    expectWrite("bp2_epc", 12'h341);
    expectWrite("bp2_cause", 12'h342);
    expectWrite("bp2_status", 12'h300);
    expectRedirect("bp2", 32'h8000_0100);
    expectIdle("bp2_done", 1'b0);
    tick();

    // Reset while in W_CAUSE aborts the trap. Only the mepc write stays committed.
    preloadCsr(32'h0000_1808, '0);
    exp_wr_q.push_back('{addr: 12'h341, data: 32'h8000_0020});
    applyStimulus(1'b1, 1'b0, 32'h8000_0020, 8'd11);
    expectAccept("rst_mid");
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    expectWrite("rst_mid_epc", 12'h341);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expectIdle("rst_mid_idle", 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expectIdle("rst_mid_quiet", 1'b0);
    end
    checkOutput("rst_mid_mstatus_kept", mstatus_m, 32'h0000_1808);
    checkOutput("rst_mid_mepc_kept", mepc_m, 32'h8000_0020);
    tick();

    // Randomized traps and mrets against the reference transforms.
    for (int i = 0; i < 3; i++) begin
      rnd_st    = $urandom();
      rnd_pc    = $urandom();
      rnd_cause = 8'($urandom_range(0, 15));
      mtvec     = $urandom();
      runTrap("rnd_trap", rnd_pc, rnd_cause, rnd_st, trapStatus(rnd_st),
              {mtvec[DW-1:2], 2'b00}, 1'b0);
      rnd_st = $urandom();
      rnd_pc = $urandom();
      runMret("rnd_mret", rnd_st, mretStatus(rnd_st), rnd_pc);
    end

    checkOutput("sb_writes_drained", 32'(exp_wr_q.size()), 0);
    checkOutput("sb_redirects_drained", 32'(exp_pc_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
